// File: rtl/cxs_tx_link_ctrl_if.sv
// CXS TX pin bundle plus the flit-source handshake seen by the TX link controller.
// master = link controller side, slave = receiver / flit-source side.
interface cxs_tx_link_ctrl_if #(
  parameter int DATA_W = 256,
  parameter int CNTL_W = 14
);
  logic              CXS_ACTIVE_REQ_TX;
  logic              CXS_ACTIVE_ACK_TX;
  logic              CXS_DEACT_HINT_TX;
  logic              CXS_CRDGNT_TX;
  logic              CXS_CRDRTN_TX;
  logic              CXS_VALID_TX;
  logic [DATA_W-1:0] CXS_DATA_TX;
  logic [CNTL_W-1:0] CXS_CNTL_TX;
  logic              flit_valid;
  logic              flit_ready;
  logic [DATA_W-1:0] flit_data;
  logic [CNTL_W-1:0] flit_cntl;

  modport master (
    output CXS_ACTIVE_REQ_TX, CXS_CRDRTN_TX, CXS_VALID_TX, CXS_DATA_TX, CXS_CNTL_TX, flit_ready,
    input  CXS_ACTIVE_ACK_TX, CXS_DEACT_HINT_TX, CXS_CRDGNT_TX, flit_valid, flit_data, flit_cntl
  );

  modport slave (
    input  CXS_ACTIVE_REQ_TX, CXS_CRDRTN_TX, CXS_VALID_TX, CXS_DATA_TX, CXS_CNTL_TX, flit_ready,
    output CXS_ACTIVE_ACK_TX, CXS_DEACT_HINT_TX, CXS_CRDGNT_TX, flit_valid, flit_data, flit_cntl
  );
endinterface

// File: rtl/cxs_tx_link_ctrl.sv
// CXS TX link controller: activation handshake, credit tracking, flit gating and
// credit return on deactivation.
module cxs_tx_link_ctrl #(
  parameter int CXS_DATA_FLIT_WIDTH = 256,
  parameter int CXS_CNTL_WIDTH      = 14,
  parameter int MAX_CREDITS         = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               link_en,
  cxs_tx_link_ctrl_if.master cxs,
  output logic [1:0]         link_state,
  output logic [3:0]         credit_cnt,
  output logic               proto_err
);

  typedef enum logic [1:0] {
    ST_STOP       = 2'd0,
    ST_ACTIVATE   = 2'd1,
    ST_RUN        = 2'd2,
    ST_DEACTIVATE = 2'd3
  } state_e;

  localparam logic [3:0] MAX_CR = 4'(MAX_CREDITS);

  state_e                         state, state_nxt;
  logic [3:0]                     credits, credits_nxt;
  logic                           err, err_nxt;
  logic                           req, req_nxt;
  logic                           rtn;
  logic                           valid;
  logic [CXS_DATA_FLIT_WIDTH-1:0] data;
  logic [CXS_CNTL_WIDTH-1:0]      cntl;
  logic                           ready, accept, ret, gnt_ok;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_STOP;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_STOP:       if (link_en && !cxs.CXS_DEACT_HINT_TX) state_nxt = ST_ACTIVATE;
      ST_ACTIVATE:   if (cxs.CXS_ACTIVE_ACK_TX)             state_nxt = ST_RUN;
      ST_RUN:        if (!link_en || cxs.CXS_DEACT_HINT_TX) state_nxt = ST_DEACTIVATE;
      ST_DEACTIVATE: if (!cxs.CXS_ACTIVE_ACK_TX && credits == 4'd0) state_nxt = ST_STOP;
      default:       state_nxt = ST_STOP;
    endcase
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    ready       = (state == ST_RUN) && (credits != 4'd0);
    accept      = cxs.flit_valid && ready;
    ret         = (state == ST_DEACTIVATE) && (credits != 4'd0);
    gnt_ok      = cxs.CXS_CRDGNT_TX && (state != ST_STOP);
    req_nxt     = (state_nxt == ST_ACTIVATE) || (state_nxt == ST_RUN);
    credits_nxt = credits;
    err_nxt     = err;
    if (cxs.CXS_CRDGNT_TX && state == ST_STOP) err_nxt = 1'b1;
    // accept and return never coincide: they belong to different states
    if (gnt_ok && !(accept || ret)) begin
      if (credits == MAX_CR) err_nxt = 1'b1;
      else                   credits_nxt = credits + 4'd1;
    end else if (!gnt_ok && (accept || ret)) begin
      credits_nxt = credits - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credits <= 4'd0;
      err     <= 1'b0;
      req     <= 1'b0;
      rtn     <= 1'b0;
      valid   <= 1'b0;
      data    <= '0;
      cntl    <= '0;
    end else begin
      credits <= credits_nxt;
      err     <= err_nxt;
      req     <= req_nxt;
      rtn     <= ret;
      valid   <= accept;
      if (accept) begin
        data <= cxs.flit_data;
        cntl <= cxs.flit_cntl;
      end
    end
  end

  assign cxs.CXS_ACTIVE_REQ_TX = req;
  assign cxs.CXS_CRDRTN_TX     = rtn;
  assign cxs.CXS_VALID_TX      = valid;
  assign cxs.CXS_DATA_TX       = data;
  assign cxs.CXS_CNTL_TX       = cntl;
  assign cxs.flit_ready        = ready;
  assign link_state            = state;
  assign credit_cnt            = credits;
  assign proto_err             = err;

endmodule

// File: tb/tb_cxs_tx_link_ctrl.sv
// Bench for cxs_tx_link_ctrl: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_cxs_tx_link_ctrl;
  localparam int DW   = 256;
  localparam int CW   = 14;
  localparam int MAXC = 15;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       link_en = 1'b0;
  logic [1:0] link_state;
  logic [3:0] credit_cnt;
  logic       proto_err;

  int n_checks = 0;
  int n_errors = 0;

  cxs_tx_link_ctrl_if #(.DATA_W(DW), .CNTL_W(CW)) cxs ();

  cxs_tx_link_ctrl #(
    .CXS_DATA_FLIT_WIDTH(DW),
    .CXS_CNTL_WIDTH(CW),
    .MAX_CREDITS(MAXC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .link_en(link_en),
    .cxs(cxs),
    .link_state(link_state),
    .credit_cnt(credit_cnt),
    .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: integer state number and credit count derived from the
  // link rules; updated on the same edge the DUT samples its inputs.
  int              m_state = 0;
  int              m_cr = 0;
  bit              m_err = 0, m_req = 0, m_rtn = 0, m_valid = 0;
  logic [DW-1:0]   m_data = '0;
  logic [CW-1:0]   m_cntl = '0;

  always @(posedge clk) begin : ref_model
    int cr_nxt;
    int st_nxt;
    bit acc, ret, gnt_ok, err_nxt;
    if (reset) begin
      m_state <= 0; m_cr <= 0; m_err <= 0; m_req <= 0;
      m_rtn <= 0; m_valid <= 0; m_data <= '0; m_cntl <= '0;
    end else begin
      acc     = cxs.flit_valid && m_state == 2 && m_cr > 0;
      ret     = m_state == 3 && m_cr > 0;
      gnt_ok  = cxs.CXS_CRDGNT_TX && m_state != 0;
      cr_nxt  = m_cr + int'(gnt_ok) - int'(acc) - int'(ret);
      err_nxt = m_err || (cxs.CXS_CRDGNT_TX && m_state == 0) || (cr_nxt > MAXC);
      if (cr_nxt > MAXC) cr_nxt = MAXC;
      case (m_state)
        0:       st_nxt = (link_en && !cxs.CXS_DEACT_HINT_TX) ? 1 : 0;
        1:       st_nxt = cxs.CXS_ACTIVE_ACK_TX ? 2 : 1;
        2:       st_nxt = (!link_en || cxs.CXS_DEACT_HINT_TX) ? 3 : 2;
        default: st_nxt = (!cxs.CXS_ACTIVE_ACK_TX && m_cr == 0) ? 0 : 3;
      endcase
      m_state <= st_nxt;
      m_cr    <= cr_nxt;
      m_err   <= err_nxt;
      m_req   <= (st_nxt == 1 || st_nxt == 2);
      m_rtn   <= ret;
      m_valid <= acc;
      if (acc) begin
        m_data <= cxs.flit_data;
        m_cntl <= cxs.flit_cntl;
      end
    end
  end

  always @(negedge clk) begin : compare
    check("link_state", DW'(link_state), DW'(m_state));
    check("credit_cnt", DW'(credit_cnt), DW'(m_cr));
    check("proto_err",  DW'(proto_err),  DW'(m_err));
    check("req",        DW'(cxs.CXS_ACTIVE_REQ_TX), DW'(m_req));
    check("crdrtn",     DW'(cxs.CXS_CRDRTN_TX), DW'(m_rtn));
    check("valid",      DW'(cxs.CXS_VALID_TX), DW'(m_valid));
    check("data",       cxs.CXS_DATA_TX, m_data);
    check("cntl",       DW'(cxs.CXS_CNTL_TX), DW'(m_cntl));
    check("flit_ready", DW'(cxs.flit_ready), DW'(m_state == 2 && m_cr != 0));
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic new_flit();
    cxs.flit_data = {8{$urandom()}};
    cxs.flit_cntl = CW'($urandom());
  endtask

  initial begin
    int cnt;
    cxs.CXS_ACTIVE_ACK_TX = 1'b0;
    cxs.CXS_DEACT_HINT_TX = 1'b0;
    cxs.CXS_CRDGNT_TX     = 1'b0;
    cxs.flit_valid        = 1'b0;
    cxs.flit_data         = '0;
    cxs.flit_cntl         = '0;

    step(); step();
    reset = 1'b0;
    step();
    check("rst_state", DW'(link_state), 0);
    check("rst_req",   DW'(cxs.CXS_ACTIVE_REQ_TX), 0);
    check("rst_cred",  DW'(credit_cnt), 0);
    check("rst_err",   DW'(proto_err), 0);
    check("rst_valid", DW'(cxs.CXS_VALID_TX), 0);

    // activation, ACK a few cycles after REQ
    link_en = 1'b1;
    step();
    check("act_state", DW'(link_state), 1);
    check("act_req",   DW'(cxs.CXS_ACTIVE_REQ_TX), 1);
    step(); step();
    check("act_hold",  DW'(link_state), 1);
    cxs.CXS_ACTIVE_ACK_TX = 1'b1;
    step();
    check("run_state", DW'(link_state), 2);
    check("run_ready_no_credit", DW'(cxs.flit_ready), 0);

    // four grants, then six cycles of flit_valid
    cxs.CXS_CRDGNT_TX = 1'b1;
    repeat (4) step();
    cxs.CXS_CRDGNT_TX = 1'b0;
    check("four_credits", DW'(credit_cnt), 4);
    cnt = 0;
    cxs.flit_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 6) cxs.flit_valid = 1'b0;
      new_flit();
      step();
      if (cxs.CXS_VALID_TX) cnt++;
    end
    check("limit_flits", DW'(cnt), 4);
    check("limit_cred",  DW'(credit_cnt), 0);
    check("limit_ready", DW'(cxs.flit_ready), 0);

    // simultaneous grant and accept
    cxs.CXS_CRDGNT_TX = 1'b1;
    repeat (2) step();
    cnt = 0;
    cxs.flit_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      new_flit();
      step();
      if (cxs.CXS_VALID_TX) cnt++;
    end
    cxs.flit_valid = 1'b0;
    cxs.CXS_CRDGNT_TX = 1'b0;
    check("simul_flits", DW'(cnt), 5);
    check("simul_cred",  DW'(credit_cnt), 2);

    // deactivate by hint with three credits
    cxs.CXS_CRDGNT_TX = 1'b1;
    step();
    cxs.CXS_CRDGNT_TX = 1'b0;
    cxs.CXS_DEACT_HINT_TX = 1'b1;
    step();
    check("deact_state", DW'(link_state), 3);
    check("deact_req",   DW'(cxs.CXS_ACTIVE_REQ_TX), 0);
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (cxs.CXS_CRDRTN_TX) cnt++;
    end
    check("deact_returns", DW'(cnt), 3);
    check("deact_wait_ack", DW'(link_state), 3);
    link_en = 1'b0;
    cxs.CXS_DEACT_HINT_TX = 1'b0;
    cxs.CXS_ACTIVE_ACK_TX = 1'b0;
    step();
    check("stop_state", DW'(link_state), 0);

    // grant in STOP
    cxs.CXS_CRDGNT_TX = 1'b1;
    step();
    cxs.CXS_CRDGNT_TX = 1'b0;
    check("stop_gnt_err",  DW'(proto_err), 1);
    check("stop_gnt_cred", DW'(credit_cnt), 0);
    reset = 1'b1; step(); reset = 1'b0; step();
    check("err_cleared", DW'(proto_err), 0);

    // overflow: 16 grants
    link_en = 1'b1; step();
    cxs.CXS_ACTIVE_ACK_TX = 1'b1; step();
    cxs.CXS_CRDGNT_TX = 1'b1;
    repeat (16) step();
    cxs.CXS_CRDGNT_TX = 1'b0;
    check("ovf_cred", DW'(credit_cnt), 15);
    check("ovf_err",  DW'(proto_err), 1);

    // reset in RUN with seven credits
    reset = 1'b1; step();
    reset = 1'b0; step();
    cxs.CXS_CRDGNT_TX = 1'b1;
    repeat (7) step();
    cxs.CXS_CRDGNT_TX = 1'b0;
    check("pre_rst_cred",  DW'(credit_cnt), 7);
    check("pre_rst_state", DW'(link_state), 2);
    link_en = 1'b0;
    reset = 1'b1;
    step();
    check("mid_rst_state", DW'(link_state), 0);
    check("mid_rst_cred",  DW'(credit_cnt), 0);
    check("mid_rst_req",   DW'(cxs.CXS_ACTIVE_REQ_TX), 0);
    check("mid_rst_valid", DW'(cxs.CXS_VALID_TX), 0);
    reset = 1'b0;
    cxs.CXS_ACTIVE_ACK_TX = 1'b0;
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (cxs.CXS_CRDRTN_TX) cnt++;
    end
    check("mid_rst_no_rtn", DW'(cnt), 0);

    // randomized traffic; the compare process checks every cycle
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 249) == 0);
      if ($urandom_range(0, 39) == 0) link_en = ~link_en;
      cxs.CXS_DEACT_HINT_TX = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 3) == 0) cxs.CXS_ACTIVE_ACK_TX = cxs.CXS_ACTIVE_REQ_TX;
      cxs.CXS_CRDGNT_TX = ($urandom_range(0, 2) == 0) &&
                          (link_state != 2'd0 || $urandom_range(0, 50) == 0);
      cxs.flit_valid = ($urandom_range(0, 2) != 0);
      new_flit();
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
